// File: rtl/pdp11_operand_fetch.sv
// Multi-cycle PDP-11 operand fetch covering addressing modes 0-7 over a req/ack read port.
// Optional macro PDP11_ODD_ADDR_TRAP_EN: odd word accesses abort with err instead of clearing lane bits.
module pdp11_operand_fetch #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 16,
  parameter int SP_PC_FULL_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [2:0]        regnum,
  input  logic              byte_mode,
  output logic [2:0]        reg_raddr,
  input  logic [ADDR_W-1:0] reg_rdata,
  output logic              reg_we,
  output logic [2:0]        reg_waddr,
  output logic [ADDR_W-1:0] reg_wdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] operand,
  output logic [ADDR_W-1:0] ea,
  output logic              ea_valid,
  output logic              err
);
  localparam int                WORD_BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WSTEP      = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] BSTEP      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LANE_MASK  = ADDR_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG_RD,
    S_IDX_FETCH,
    S_PTR_FETCH,
    S_DATA_FETCH,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [2:0]          regnum_q, regnum_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic                ea_valid_q, ea_valid_d;
  logic                reg_we_q, reg_we_d;
  logic [2:0]          reg_waddr_q, reg_waddr_d;
  logic [ADDR_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic [2:0]          reg_raddr_c;
  logic                mem_req_c;
  logic [ADDR_W-1:0]   mem_addr_c;
`ifdef PDP11_ODD_ADDR_TRAP_EN
  logic                err_q, err_d;
`endif

  // Pointer modes (3, 5) always step a full word; byte SP/PC may be forced to a word step.
  function automatic logic [ADDR_W-1:0] step_of(input logic [2:0] m, input logic [2:0] rn,
                                                input logic b);
    if (!b || m == 3'd3 || m == 3'd5) return WSTEP;
    if (SP_PC_FULL_STEP != 0 && rn >= 3'd6) return WSTEP;
    return BSTEP;
  endfunction

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~LANE_MASK;
  endfunction

  function automatic logic [DATA_W-1:0] lane_byte(input logic [DATA_W-1:0] w,
                                                  input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] sh;
    sh = w >> (32'(a & LANE_MASK) * 8);
    return sh & DATA_W'(8'hFF);
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    regnum_d    = regnum_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    operand_d   = operand_q;
    ea_d        = ea_q;
    ea_valid_d  = ea_valid_q;
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    reg_raddr_c = regnum_q;
    mem_req_c   = 1'b0;
    mem_addr_c  = '0;
`ifdef PDP11_ODD_ADDR_TRAP_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          regnum_d   = regnum;
          byte_d     = byte_mode;
          operand_d  = '0;
          ea_d       = '0;
          ea_valid_d = 1'b0;
`ifdef PDP11_ODD_ADDR_TRAP_EN
          err_d      = 1'b0;
`endif
          state_d    = S_REG_RD;
        end
      end
      S_REG_RD: begin
        case (mode_q)
          3'd0: begin
            operand_d = DATA_W'(reg_rdata);
            state_d   = S_DONE;
          end
          3'd1: begin
            addr_d  = reg_rdata;
            state_d = S_DATA_FETCH;
          end
          3'd2, 3'd3: begin
            addr_d      = reg_rdata;
            reg_we_d    = 1'b1;
            reg_waddr_d = regnum_q;
            reg_wdata_d = reg_rdata + step_of(mode_q, regnum_q, byte_q);
            state_d     = (mode_q == 3'd3) ? S_PTR_FETCH : S_DATA_FETCH;
          end
          3'd4, 3'd5: begin
            addr_d      = reg_rdata - step_of(mode_q, regnum_q, byte_q);
            reg_we_d    = 1'b1;
            reg_waddr_d = regnum_q;
            reg_wdata_d = reg_rdata - step_of(mode_q, regnum_q, byte_q);
            state_d     = (mode_q == 3'd5) ? S_PTR_FETCH : S_DATA_FETCH;
          end
          default: begin
            addr_d  = reg_rdata;
            state_d = S_IDX_FETCH;
          end
        endcase
      end
      S_IDX_FETCH: begin
        // PC is not written until the index word arrives, so the request address stays stable.
        reg_raddr_c = 3'd7;
        mem_req_c   = 1'b1;
        mem_addr_c  = align(reg_rdata);
        if (mem_ack) begin
          reg_we_d    = 1'b1;
          reg_waddr_d = 3'd7;
          reg_wdata_d = reg_rdata + WSTEP;
          addr_d      = ((regnum_q == 3'd7) ? reg_rdata + WSTEP : addr_q) + ADDR_W'(mem_rdata);
          state_d     = mode_q[0] ? S_PTR_FETCH : S_DATA_FETCH;
        end
      end
      S_PTR_FETCH: begin
`ifdef PDP11_ODD_ADDR_TRAP_EN
        if ((addr_q & LANE_MASK) != '0) begin
          err_d      = 1'b1;
          operand_d  = '0;
          ea_d       = addr_q;
          ea_valid_d = 1'b1;
          state_d    = S_DONE;
        end else
`endif
        begin
          mem_req_c  = 1'b1;
          mem_addr_c = align(addr_q);
          if (mem_ack) begin
            addr_d  = ADDR_W'(mem_rdata);
            state_d = S_DATA_FETCH;
          end
        end
      end
      S_DATA_FETCH: begin
`ifdef PDP11_ODD_ADDR_TRAP_EN
        if (!byte_q && (addr_q & LANE_MASK) != '0) begin
          err_d      = 1'b1;
          operand_d  = '0;
          ea_d       = addr_q;
          ea_valid_d = 1'b1;
          state_d    = S_DONE;
        end else
`endif
        begin
          mem_req_c  = 1'b1;
          mem_addr_c = align(addr_q);
          if (mem_ack) begin
            operand_d  = byte_q ? lane_byte(mem_rdata, addr_q) : mem_rdata;
            ea_d       = addr_q;
            ea_valid_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible results clear on reset; a pending writeback is dropped with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      operand_q   <= '0;
      ea_q        <= '0;
      ea_valid_q  <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
`ifdef PDP11_ODD_ADDR_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      ea_q        <= ea_d;
      ea_valid_q  <= ea_valid_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
`ifdef PDP11_ODD_ADDR_TRAP_EN
      err_q       <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    mode_q   <= mode_d;
    regnum_q <= regnum_d;
    byte_q   <= byte_d;
    addr_q   <= addr_d;
  end

  assign reg_raddr = reg_raddr_c;
  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign mem_req   = mem_req_c;
  assign mem_addr  = mem_addr_c;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign operand   = operand_q;
  assign ea        = ea_q;
  assign ea_valid  = ea_valid_q;
`ifdef PDP11_ODD_ADDR_TRAP_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/pdp11_operand_fetch.md
Name: pdp11_operand_fetch

Overview:
- Sequential operand-fetch engine implementing all eight PDP-11 addressing modes (0-7) for one source or destination specifier.
- Multi-cycle FSM replacing the single-step combinational operand lookup: register-file read/writeback, index-word fetch from the instruction stream, deferred address fetch, and byte/word data fetch over a req/ack memory handshake.
- Sits between instruction decode and the execute stage; invoked once per operand.

Parameters:
- DATA_W, 16, data/word width in bits; multiple of 8; WORD_BYTES = DATA_W/8.
- ADDR_W, 16, address and register width; EA arithmetic is modulo 2^ADDR_W.
- SP_PC_FULL_STEP, 1, when 1, byte-mode autoinc/autodec of R6/R7 steps WORD_BYTES instead of 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request fetch; sampled only in IDLE
- mode  in  3  addressing mode, latched on start
- regnum  in  3  register specifier, latched on start
- byte_mode  in  1  1 = byte operand, latched on start
- reg_raddr  out  3  register-file read address
- reg_rdata  in  ADDR_W  combinational read data for reg_raddr
- reg_we  out  1  register writeback strobe, 1-cycle pulse
- reg_waddr  out  3  writeback register
- reg_wdata  out  ADDR_W  writeback value
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  word-aligned read address (lane bits zero)
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  read data
- busy  out  1  high from the cycle after start until done
- done  out  1  1-cycle completion pulse
- operand  out  DATA_W  fetched value; byte results zero-extended; held until next start
- ea  out  ADDR_W  effective address; held until next start
- ea_valid  out  1  0 for mode 0, 1 otherwise
- err  out  1  alignment error flag; 0 unless PDP11_ODD_ADDR_TRAP_EN

Behaviour:
- Reset: state IDLE. All outputs are 0: busy, done, mem_req, reg_we, operand, ea, ea_valid, err. A reset mid-operation aborts immediately and drops any pending writeback and request.
- States: IDLE, REG_RD, IDX_FETCH, PTR_FETCH, DATA_FETCH, DONE.
- IDLE: on start, latch the inputs and go to REG_RD. start while busy is ignored.
- Step size: step = 1 for byte access, except R6/R7 when SP_PC_FULL_STEP=1; otherwise step = WORD_BYTES. Mode 3 and mode 5 always use WORD_BYTES (pointer).
- REG_RD: read regnum into base.
  - Mode 0: operand = base (truncated or extended to DATA_W); go to DONE.
  - Modes 1-3: addr = base. For modes 2/3, write back base+step with reg_we.
  - Modes 4-5: addr = base-step, written back with reg_we.
  - Modes 6-7: go to IDX_FETCH.
- IDX_FETCH:
  - Read R7 and request mem at R7; on ack, write back R7+WORD_BYTES.
  - ea_base = base, or R7+WORD_BYTES when regnum=7.
  - addr = ea_base + index.
- Modes 3, 5, 7 then go to PTR_FETCH, which fetches a word at addr and sets addr = mem_rdata. Modes 1, 2, 4, 6 go to DATA_FETCH.
- DATA_FETCH:
  - ea = addr; mem_addr = addr with lane bits cleared.
  - Byte access: operand = lane selected by addr[log2(WORD_BYTES)-1:0], zero-extended.
  - Word access: lane bits ignored.
- Handshake:
  - mem_req and mem_addr are held stable until a cycle with mem_ack=1. Data is captured on that edge and mem_req drops the next cycle.
  - An ack while mem_req=0 is ignored. No limit on wait cycles.
- Writeback timing: at most one reg_we per register update, asserted in the cycle following the state that computed it. Register side effects are never repeated on handshake wait.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start may be asserted in the DONE cycle and is sampled next cycle.
- Latency with zero-wait ack (start sampled at edge 0):
  - Mode 0: done in cycle 2.
  - Modes 1/2/4: cycle 3.
  - Modes 3/5/6: cycle 4.
  - Mode 7: cycle 5.

Optional Feature:
- Macro: PDP11_ODD_ADDR_TRAP_EN.
- When defined: a word access (data or pointer) with nonzero lane bits issues no request and goes to DONE with err=1 and operand=0. Register writebacks already issued stand.
- When undefined: err is tied to 0 and lane bits are silently cleared.

Test Plan:
- Mode 0, R3=16'o001234, word -> done cycle 2, operand=16'o001234, ea_valid=0, no mem_req, no reg_we.
- Mode 2, R1=16'o1000, byte, mem[16'o1000]=16'hAB12 -> operand=16'h0012, ea=16'o1000, R1 written 16'o1001.
- Mode 2, R6=16'o2000, byte, SP_PC_FULL_STEP=1 -> R6 written 16'o2002.
- Mode 4, R2=16'o1002, byte, high lane: R2 written 16'o1001, mem_addr=16'o1000, mem_rdata=16'hAB12 -> operand=16'h00AB.
- Mode 6, R4=16'o100, PC=16'o500, mem[16'o500]=16'o20, mem[16'o120]=16'h5A5A, ack delayed 3 cycles -> PC written 16'o502, ea=16'o120, operand=16'h5A5A, mem_req stable during wait.
- Reset asserted in PTR_FETCH of a mode 7 fetch -> next cycle all outputs 0, no reg_we; then mode 3 on R0=16'o3000 with macro defined and mem[16'o3000]=16'o3001 -> err=1, operand=0, R0 written 16'o3002.
